// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: issues one memory read at a time,
// holds the returned word for decode, and honours branch/jump redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        kill;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ~32'h3;

    // NOTE: imem_req is decoded combinationally so a same-cycle redirect or
    // reset suppresses the request before the memory can accept it.
    assign imem_req  = (state == FETCH) && !reset && !redirect_valid;
    assign imem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of pc, kill and state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_pc      <= '0;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
            pc_out      <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end else if (imem_ready) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect_valid) begin
                            // Response belongs to a squashed fetch: drop it.
                            kill  <= 1'b0;
                            state <= FETCH;
                            if (redirect_valid) pc <= redirect_target;
                        end else begin
                            instr_out   <= imem_rdata;
                            pc_out      <= req_pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_target;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_target;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, the byte address of the first instruction fetched after reset.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1 bit; high means the downstream decode stage cannot consume instr_out this cycle.
REQ-005 The block SHALL have port redirect_valid, input, 1 bit, a request to change fetch flow (branch or jump taken).
REQ-006 The block SHALL have port redirect_pc, input, 32 bits, the new fetch address, used only when redirect_valid=1.
REQ-007 The block SHALL have port imem_req, output, 1 bit, the instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits, the read address, valid while imem_req=1.
REQ-009 The block SHALL have port imem_ready, input, 1 bit; the memory accepts the request in a cycle where imem_req=1 and imem_ready=1.
REQ-010 The block SHALL have port imem_rvalid, input, 1 bit, which marks read data valid, at least one cycle after acceptance.
REQ-011 The block SHALL have port imem_rdata, input, 32 bits, the instruction word, sampled when imem_rvalid=1.
REQ-012 The block SHALL have port instr_out, output, 32 bits, the fetched instruction presented to decode.
REQ-013 The block SHALL have port pc_out, output, 32 bits, the byte address of instr_out.
REQ-014 The block SHALL have port instr_valid, output, 1 bit; high means instr_out and pc_out hold an unconsumed instruction.

Function
REQ-015 The block SHALL implement states FETCH, WAIT and HOLD, with a 32-bit pc register, a 32-bit req_pc register and a 1-bit kill flag.
REQ-016 imem_req SHALL be 1 only in FETCH with reset=0 and redirect_valid=0; imem_addr SHALL equal pc at all times.
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 FETCH with redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}; stay in FETCH; no request is issued that cycle.
REQ-019 FETCH with the request accepted: req_pc <= pc; pc <= pc+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0); go to WAIT.
REQ-020 FETCH with imem_ready=0: hold pc and imem_req; remain in FETCH.
REQ-021 WAIT with imem_rvalid=1, kill=0 and redirect_valid=0: instr_out <= imem_rdata; pc_out <= req_pc; instr_valid <= 1; go to HOLD.
REQ-022 WAIT with redirect_valid=1 and imem_rvalid=0: pc <= aligned redirect_pc; kill <= 1; stay in WAIT.
REQ-023 WAIT with imem_rvalid=1 and (kill=1 or redirect_valid=1): discard the data; instr_valid stays 0; kill <= 0; if redirect_valid=1, pc <= aligned redirect_pc; go to FETCH.
REQ-024 HOLD with stall=0 and redirect_valid=0: the instruction is consumed this cycle; instr_valid <= 0; go to FETCH.
REQ-025 HOLD with stall=1 and redirect_valid=0: instr_out, pc_out and instr_valid SHALL be held unchanged.
REQ-026 HOLD with redirect_valid=1: instr_valid <= 0 (flush, regardless of stall); pc <= aligned redirect_pc; go to FETCH.
REQ-027 Redirect SHALL take priority over every other event in the same cycle.
REQ-028 instr_out and pc_out SHALL change only on REQ-021 loads and on reset.
REQ-029 Steady-state latency SHALL be: request accepted in cycle N, rvalid in N+1, instr_valid high from N+2; with a 1-cycle memory and stall=0, throughput is one instruction per 3 cycles.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 While reset=1 the block SHALL force, at the clock edge: state=FETCH, pc=RESET_PC, req_pc=0, kill=0, instr_valid=0, instr_out=32'h00000013 (nop), pc_out=0.
REQ-032 imem_req SHALL be 0 in every cycle where reset=1.
REQ-033 Reset asserted in WAIT SHALL abandon the outstanding request; a later imem_rvalid arriving in FETCH SHALL be ignored.
REQ-034 The first request after reset deasserts SHALL be issued in that same cycle, with address RESET_PC.

Verification
REQ-035 Reset, then 1-cycle memory returning 32'h00000033 at address 0 and stall=0 -> imem_addr 0, 4, 8 on successive requests; instr_valid high for one cycle with instr_out=32'h00000033 and pc_out=0.
REQ-036 stall=1 for 5 cycles while in HOLD -> instr_out, pc_out and instr_valid stable for those 5 cycles; no request issued; after stall=0, next imem_addr = pc_out+4.
REQ-037 redirect_valid=1, redirect_pc=32'h00000103 while in WAIT, rvalid 2 cycles later -> data dropped, instr_valid stays 0, next imem_addr=32'h00000100.
REQ-038 redirect_valid=1 in HOLD with stall=1 -> instr_valid=0 next cycle; next request address equals aligned redirect_pc.
REQ-039 RESET_PC=32'hFFFFFFFC with a 1-cycle memory -> first imem_addr=32'hFFFFFFFC, second imem_addr=0.
REQ-040 Reset pulsed while in WAIT, then stray imem_rvalid with data 32'hDEADBEEF -> instr_valid stays 0, instr_out=32'h00000013, next imem_addr=RESET_PC.
